arbitro_roteador: RTL

//  Upstream controller for the 2:1 router (roteador). Arbitrates two valid/ready

---
 rtl/arbitro_roteador.sv | 108 ++++++++++
 1 files changed

// File: rtl/arbitro_roteador.sv
// arbitro_roteador: round-robin, burst-bounded arbiter driving a 2:1 router SEL, with a 1-deep registered output stage
// Ports:
//   clock_i      rising-edge clock
//   reset_n_i    asynchronous active-low reset
//   a_valid_i    source A has a word on the router's A input
//   a_ready_o    A's word is taken this cycle
//   b_valid_i    source B has a word on the router's B input
//   b_ready_o    B's word is taken this cycle
//   sel_o        router SEL (0 = A, 1 = B)
//   mux_data_i   router output, combinational in sel_o
//   out_valid_o  out_data_o holds a word
//   out_data_o   registered captured word
//   out_ready_i  downstream accepts out_data_o this cycle
module arbitro_roteador #(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             a_valid_i,
  output logic             a_ready_o,
  input  logic             b_valid_i,
  output logic             b_ready_o,
  output logic             sel_o,
  input  logic [WIDTH-1:0] mux_data_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i
);
  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_e;
  state_e state_q, state_d;
  logic last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sel_q, sel_d;
  logic out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic can_accept, xfer_a, xfer_b, xfer, own_valid, rel;
  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      sel_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  // last_q: 0 = A was granted most recently, 1 = B
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    own_valid = state_q == GNT_A ? a_valid_i : b_valid_i;
    rel       = (xfer && cnt_q == LAST_BEAT) || !own_valid;
    case (state_q)
      IDLE:
        if (a_valid_i && (!b_valid_i || last_q)) begin
          state_d = GNT_A;
          last_d  = 1'b0;
          cnt_d   = '0;
        end else if (b_valid_i) begin
          state_d = GNT_B;
          last_d  = 1'b1;
          cnt_d   = '0;
        end
      GNT_A:
        if (!rel) cnt_d = cnt_q + CW'(xfer_a);
        else if (b_valid_i) begin
          state_d = GNT_B;
          last_d  = 1'b1;
          cnt_d   = '0;
        end else if (a_valid_i) cnt_d = '0;
        else state_d = IDLE;
      GNT_B:
        if (!rel) cnt_d = cnt_q + CW'(xfer_b);
        else if (a_valid_i) begin
          state_d = GNT_A;
          last_d  = 1'b0;
          cnt_d   = '0;
        end else if (b_valid_i) cnt_d = '0;
        else state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // SEL follows the grant a cycle ahead so it is registered and holds through IDLE
    sel_d = state_d == GNT_B ? 1'b1 : state_d == GNT_A ? 1'b0 : sel_q;
  end
  always_comb begin
    can_accept  = !out_valid_q || out_ready_i;
    a_ready_o   = state_q == GNT_A && can_accept;
    b_ready_o   = state_q == GNT_B && can_accept;
    xfer_a      = a_ready_o && a_valid_i;
    xfer_b      = b_ready_o && b_valid_i;
    xfer        = xfer_a || xfer_b;
    out_valid_d = xfer ? 1'b1 : out_ready_i ? 1'b0 : out_valid_q;
    out_data_d  = xfer ? mux_data_i : out_data_q;
  end
  assign sel_o       = sel_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
endmodule
